// File: rtl/line_clear_flash_ctrl.sv
// Line-clear flash sequencer: blinks the completed rows in flash_map, then clears them and pulses done_out.
// Optional build macro FLASH_CTRL_RESET_CLEAR_EN adds a post-reset sweep that zeroes the map.
module line_clear_flash_ctrl #(
  parameter int NUM_ROWS         = 20,
  parameter int ROW_WIDTH        = 10,
  parameter int ROW_START_X      = 3,
  parameter int ROW_START_Y      = 1,
  parameter int MAP_WIDTH        = 14,
  parameter int ADDR_WIDTH       = 9,
  parameter int NUM_FLASHES      = 3,
  parameter int FRAMES_PER_PHASE = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  start_in,
  input  logic [NUM_ROWS-1:0]   rows_in,
  input  logic                  frame_tick_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  flash_enable_out,
  output logic [ADDR_WIDTH-1:0] flash_write_addr_out,
  output logic                  flash_write_out
);

  localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int CW = (ROW_WIDTH > 1) ? $clog2(ROW_WIDTH) : 1;
  localparam int PW = $clog2(2 * NUM_FLASHES);
  localparam int FW = $clog2(FRAMES_PER_PHASE + 1);

  localparam logic [RW-1:0]         ROW_LAST   = RW'(NUM_ROWS - 1);
  localparam logic [CW-1:0]         COL_LAST   = CW'(ROW_WIDTH - 1);
  localparam logic [PW-1:0]         PHASE_LAST = PW'(2 * NUM_FLASHES - 1);
  localparam logic [FW-1:0]         TICK_LAST  = FW'(FRAMES_PER_PHASE - 1);
  localparam logic [ADDR_WIDTH-1:0] CLR_LAST   = ADDR_WIDTH'((NUM_ROWS + ROW_START_Y) * MAP_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PAINT,
    ST_HOLD,
    ST_DONE,
    ST_CLEAR
  } state_t;

`ifdef FLASH_CTRL_RESET_CLEAR_EN
  localparam state_t RST_STATE = ST_CLEAR;
`else
  localparam state_t RST_STATE = ST_IDLE;
`endif

  state_t                  state_q, state_d;
  logic [NUM_ROWS-1:0]     mask_q, mask_d;
  logic [RW-1:0]           row_q, row_d;
  logic [CW-1:0]           col_q, col_d;
  logic [PW-1:0]           phase_q, phase_d;
  logic [FW-1:0]           tick_q, tick_d;
  logic [ADDR_WIDTH-1:0]   clr_q, clr_d;

  logic                    en_d, data_d, busy_d, done_d;
  logic [ADDR_WIDTH-1:0]   addr_d;

  function automatic logic [ADDR_WIDTH-1:0] cell_addr(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return ADDR_WIDTH'((int'(r) + ROW_START_Y) * MAP_WIDTH + int'(c) + ROW_START_X);
  endfunction

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q              <= RST_STATE;
      mask_q               <= '0;
      row_q                <= '0;
      col_q                <= '0;
      phase_q              <= '0;
      tick_q               <= '0;
      clr_q                <= '0;
      busy_out             <= 1'b0;
      done_out             <= 1'b0;
      flash_enable_out     <= 1'b0;
      flash_write_addr_out <= '0;
      flash_write_out      <= 1'b0;
    end else begin
      state_q              <= state_d;
      mask_q               <= mask_d;
      row_q                <= row_d;
      col_q                <= col_d;
      phase_q              <= phase_d;
      tick_q               <= tick_d;
      clr_q                <= clr_d;
      busy_out             <= busy_d;
      done_out             <= done_d;
      flash_enable_out     <= en_d;
      flash_write_addr_out <= addr_d;
      flash_write_out      <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    row_d   = row_q;
    col_d   = col_q;
    phase_d = phase_q;
    tick_d  = tick_q;
    clr_d   = clr_q;
    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          mask_d  = rows_in;
          row_d   = '0;
          col_d   = '0;
          phase_d = '0;
          tick_d  = '0;
          state_d = (rows_in != '0) ? ST_PAINT : ST_DONE;
        end
      end
      ST_PAINT: begin
        if (col_q == COL_LAST) begin
          col_d = '0;
          if (row_q == ROW_LAST) begin
            row_d   = '0;
            tick_d  = '0;
            state_d = (phase_q == PHASE_LAST) ? ST_DONE : ST_HOLD;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (frame_tick_in) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            phase_d = phase_q + 1'b1;
            row_d   = '0;
            col_d   = '0;
            state_d = ST_PAINT;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_CLEAR: begin
        clr_d = clr_q + 1'b1;
        if (clr_q == CLR_LAST) begin
          clr_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Paint outputs are registered from the next cell so the first write lands one cycle after start;
  // the sweep instead shows the current sweep address so it starts at 0 right after reset release.
  always_comb begin
    en_d   = 1'b0;
    addr_d = '0;
    data_d = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    if (state_q == ST_CLEAR) begin
      en_d   = 1'b1;
      addr_d = clr_q;
      busy_d = 1'b1;
    end else begin
      case (state_d)
        ST_PAINT: begin
          en_d   = mask_d[row_d];
          addr_d = cell_addr(row_d, col_d);
          data_d = ~phase_d[0];
          busy_d = 1'b1;
        end
        ST_HOLD: busy_d = 1'b1;
        ST_DONE: done_d = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_line_clear_flash_ctrl.sv
// Randomized bench for line_clear_flash_ctrl against a cell-index model of the flash animation.
// Build with FLASH_CTRL_RESET_CLEAR_EN defined to also check the post-reset clearing sweep.
module tb_line_clear_flash_ctrl;

  localparam int NR = 20;
  localparam int RWD = 10;
  localparam int SX = 3;
  localparam int SY = 1;
  localparam int MW = 14;
  localparam int NF = 3;
  localparam int FPP = 8;
  localparam int CELLS = NR * RWD;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        start_in = 1'b0;
  logic [19:0] rows_in = '0;
  logic        frame_tick_in = 1'b0;
  logic        busy_out, done_out, flash_enable_out, flash_write_out;
  logic [8:0]  flash_write_addr_out;

  int checks = 0;
  int failures = 0;

  line_clear_flash_ctrl dut (
    .clk_in               (clk_in),
    .rst_n_in             (rst_n_in),
    .start_in             (start_in),
    .rows_in              (rows_in),
    .frame_tick_in        (frame_tick_in),
    .busy_out             (busy_out),
    .done_out             (done_out),
    .flash_enable_out     (flash_enable_out),
    .flash_write_addr_out (flash_write_addr_out),
    .flash_write_out      (flash_write_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk_ctl(input string tag, input logic en, input logic busy, input logic done);
    chk({tag, ".en"}, 32'(flash_enable_out), 32'(en));
    chk({tag, ".busy"}, 32'(busy_out), 32'(busy));
    chk({tag, ".done"}, 32'(done_out), 32'(done));
  endtask

  function automatic int model_addr(input int k);
    return (k / RWD + SY) * MW + (k % RWD) + SX;
  endfunction

  task automatic do_reset();
    rst_n_in = 1'b0;
    start_in = 1'b0;
    frame_tick_in = 1'b0;
    step();
    chk_ctl("rst", 1'b0, 1'b0, 1'b0);
    chk("rst.addr", 32'(flash_write_addr_out), 32'd0);
    chk("rst.data", 32'(flash_write_out), 32'd0);
    rst_n_in = 1'b1;
`ifdef FLASH_CTRL_RESET_CLEAR_EN
    for (int i = 0; i < (NR + SY) * MW; i++) begin
      start_in = ($urandom_range(0, 7) == 0);
      rows_in  = 20'($urandom) | 20'h1;
      step();
      start_in = 1'b0;
      chk_ctl("sweep", 1'b1, 1'b1, 1'b0);
      chk("sweep.addr", 32'(flash_write_addr_out), 32'(i));
      chk("sweep.data", 32'(flash_write_out), 32'd0);
    end
`endif
    step();
    chk_ctl("post_rst_idle", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_seq(input logic [19:0] m, input bit noise);
    int ens;
    int ticks;
    int gap;
    logic t;
    rows_in  = m;
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    rows_in  = 20'($urandom);
    if (m == '0) begin
      chk_ctl("zero_done", 1'b0, 1'b0, 1'b1);
      step();
      chk_ctl("zero_idle", 1'b0, 1'b0, 1'b0);
      return;
    end
    for (int p = 0; p < 2 * NF; p++) begin
      ens = 0;
      for (int k = 0; k < CELLS; k++) begin
        chk_ctl("paint", m[k / RWD], 1'b1, 1'b0);
        chk("paint.addr", 32'(flash_write_addr_out), 32'(model_addr(k)));
        chk("paint.data", 32'(flash_write_out), 32'((p % 2) == 0));
        if (flash_enable_out === 1'b1) ens++;
        if (noise) begin
          frame_tick_in = ($urandom_range(0, 3) == 0);
          start_in      = ($urandom_range(0, 15) == 0);
          rows_in       = 20'($urandom);
        end
        step();
        frame_tick_in = 1'b0;
        start_in = 1'b0;
      end
      chk("paint.enable_count", 32'(ens), 32'(RWD * $countones(m)));
      if (p < 2 * NF - 1) begin
        ticks = 0;
        gap = 0;
        while (ticks < FPP) begin
          chk_ctl("hold", 1'b0, 1'b1, 1'b0);
          t = (gap >= 4) || ($urandom_range(0, 2) == 0);
          frame_tick_in = t;
          if (noise) begin
            start_in = ($urandom_range(0, 3) == 0);
            rows_in  = 20'($urandom);
          end
          step();
          frame_tick_in = 1'b0;
          start_in = 1'b0;
          if (t) begin
            ticks++;
            gap = 0;
          end else begin
            gap++;
          end
        end
      end
    end
    chk_ctl("done", 1'b0, 1'b0, 1'b1);
    start_in = noise;
    rows_in  = 20'($urandom) | 20'h1;
    step();
    start_in = 1'b0;
    chk_ctl("idle", 1'b0, 1'b0, 1'b0);
    step();
    chk_ctl("idle2", 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    do_reset();
    run_seq(20'h80000, 1'b0);
    run_seq(20'h80001, 1'b1);
    run_seq(20'h00000, 1'b0);

    rows_in  = 20'h0F0F0;
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    repeat ($urandom_range(5, 150)) step();
    do_reset();
    run_seq(20'h0F0F0, 1'b1);

    for (int r = 0; r < 3; r++) begin
      run_seq(20'($urandom), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
